// File: rtl/fetch_redirect_unit.sv
// -----------------------------------------------------------------------------
// fetch_redirect_unit
//
// Front-end byte fetch sequencer. Owns the architectural fetch PC, issues
// one-byte read requests to instruction memory, buffers returned bytes in a
// small in-order FIFO and presents them to the decoder together with their
// address. A redirect from the pipeline termination logic flushes the buffer,
// reloads both PCs and drains responses that were already in flight before
// fetching resumes at the new target.
//
// Parameters
//   RESET_PC        fetch PC loaded on reset
//   DEPTH           byte buffer entries; also caps buffered + outstanding bytes
//                   (power of two, 2..16)
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             synchronous active-high reset
//   redirect_valid  termination result valid this cycle
//   redirect_addr   new fetch target
//   mem_req_valid   fetch request (combinational from redirect_valid)
//   mem_req_addr    byte address requested (the fetch PC, registered)
//   mem_req_ready   memory accepts the request
//   mem_resp_valid  returned byte valid (in request order, max one per cycle)
//   mem_resp_data   returned byte
//   out_valid       byte available to the decoder (combinational from
//                   redirect_valid)
//   out_data        byte at the buffer head
//   out_pc          address of out_data
//   out_ready       decoder takes the byte
//   flushing        high while in-flight responses are being discarded
// -----------------------------------------------------------------------------
module fetch_redirect_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_addr,
  output logic        mem_req_valid,
  output logic [15:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [7:0]  mem_resp_data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic [15:0] out_pc,
  input  logic        out_ready,
  output logic        flushing
);

  // Pointer width for the buffer and counter width able to hold 0..DEPTH.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [15:0]   fetch_pc_r;
  logic [15:0]   head_pc_r;
  logic [7:0]    fifo_mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] outstanding_after_resp_s;
  logic [CW-1:0] outstanding_nxt_s;
  logic [CW:0]   occupancy_s;
  logic          run_s;
  logic          room_s;
  logic          req_fire_s;
  logic          pop_fire_s;
  logic          resp_take_s;
  logic          push_s;

  // Handshake qualification and the occupancy cap shared by both valids.
  always_comb begin
    run_s       = (state_r == ST_RUN);
    occupancy_s = {1'b0, count_r} + {1'b0, outstanding_r};
    room_s      = (occupancy_s < DEPTH_W);
    // A redirect forces both valids low so no request or pop can slip
    // through in the cycle the PCs are being reloaded.
    mem_req_valid = run_s & ~redirect_valid & room_s;
    out_valid     = run_s & ~redirect_valid & (count_r != {CW{1'b0}});
    req_fire_s    = mem_req_valid & mem_req_ready;
    pop_fire_s    = out_valid & out_ready;
    // A response with nothing outstanding violates the memory contract; it is
    // ignored so the counter saturates at zero and the byte is dropped.
    resp_take_s   = mem_resp_valid & (outstanding_r != {CW{1'b0}});
    // Responses are only kept in RUN outside a redirect cycle; otherwise they
    // belong to a stale fetch stream.
    push_s        = resp_take_s & run_s & ~redirect_valid;
  end

  // Outstanding-request bookkeeping.
  always_comb begin
    outstanding_after_resp_s = outstanding_r - CW'(resp_take_s);
    outstanding_nxt_s        = outstanding_after_resp_s + CW'(req_fire_s);
  end

  // Buffer occupancy update; a redirect empties the buffer.
  always_comb begin
    count_nxt_s = count_r;
    if (redirect_valid) begin
      count_nxt_s = {CW{1'b0}};
    end else begin
      case ({push_s, pop_fire_s})
        2'b10:   count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Next-state logic: stay in DRAIN until every in-flight response is gone.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (redirect_valid) begin
          if (outstanding_after_resp_s != {CW{1'b0}}) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // A redirect while draining follows the same rule, so no separate
        // branch is needed for it here.
        if (outstanding_after_resp_s == {CW{1'b0}}) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Fetch PC: reload on redirect, advance by one byte per accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_r <= redirect_addr;
    end else if (req_fire_s) begin
      fetch_pc_r <= fetch_pc_r + 16'h0001;
    end
  end

  // Head PC: address of the byte at the buffer head.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      head_pc_r <= redirect_addr;
    end else if (pop_fire_s) begin
      head_pc_r <= head_pc_r + 16'h0001;
    end
  end

  // Buffer pointers; DEPTH is a power of two so they wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else if (redirect_valid) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_fire_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Occupancy and outstanding counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r       <= {CW{1'b0}};
      outstanding_r <= {CW{1'b0}};
    end else begin
      count_r       <= count_nxt_s;
      outstanding_r <= outstanding_nxt_s;
    end
  end

  // Byte storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= mem_resp_data;
    end
  end

  // Registered outputs.
  always_comb begin
    mem_req_addr = fetch_pc_r;
    out_data     = fifo_mem_r[rd_ptr_r];
    out_pc       = head_pc_r;
    flushing     = (state_r == ST_DRAIN);
  end

  fetch_redirect_unit_checker #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_checker (
    .clk         (clk),
    .rst         (rst),
    .count       (count_r),
    .outstanding (outstanding_r),
    .push        (push_s),
    .pop         (pop_fire_s)
  );

endmodule

// -----------------------------------------------------------------------------
// fetch_redirect_unit_checker
//
// Occupancy invariants of the fetch buffer: the buffer never exceeds DEPTH,
// buffered plus outstanding bytes never exceed DEPTH, and a byte is never
// pushed into a full buffer unless one leaves in the same cycle.
//
// Ports
//   clk, rst     clock and synchronous reset of the parent
//   count        buffered byte count
//   outstanding  requests issued but not yet answered
//   push, pop    buffer write and read strobes
// -----------------------------------------------------------------------------
module fetch_redirect_unit_checker #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic [CW-1:0] count,
  input logic [CW-1:0] outstanding,
  input logic          push,
  input logic          pop
);

  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, count} <= DEPTH_W));

  a_occupancy_bound: assert property (@(posedge clk) disable iff (rst)
    (({1'b0, count} + {1'b0, outstanding}) <= DEPTH_W));

  a_no_overflow_push: assert property (@(posedge clk) disable iff (rst)
    (push |-> (({1'b0, count} != DEPTH_W) || pop)));

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// -----------------------------------------------------------------------------
// Bench for fetch_redirect_unit. A memory model answers each accepted request
// with the low byte of its address one cycle later (responses can be held
// back). Expected decoder bytes are queued when each stimulus phase starts and
// a negedge monitor pops and compares them on every output handshake; request
// addresses are compared against a running expected fetch address.
// -----------------------------------------------------------------------------
module tb_fetch_redirect_unit;

  localparam logic [15:0] RST_PC = 16'hC000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_addr = 16'h0000;
  logic        mem_req_valid;
  logic [15:0] mem_req_addr;
  logic        mem_req_ready = 1'b1;
  logic        mem_resp_valid = 1'b0;
  logic [7:0]  mem_resp_data = 8'h00;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [15:0] out_pc;
  logic        out_ready = 1'b1;
  logic        flushing;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [23:0] exp_q [$];
  logic [15:0] pend [$];
  logic [15:0] req_model = RST_PC;
  logic [15:0] resp_tmp;
  logic [23:0] exp_tmp;
  int          req_cnt = 0;
  int          cyc = 0;
  int          pop_cyc [$];
  bit          resp_en = 1'b1;

  fetch_redirect_unit #(
    .RESET_PC (RST_PC),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .flushing       (flushing)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
    #1;
  endtask

  task automatic exp_range(input logic [15:0] start, input int n);
    logic [15:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({p, p[7:0]});
      p = p + 16'h0001;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, exp_q.size(), 0);
    repeat (3) tick();
  endtask

  // Monitor: request addresses and decoder output handshakes.
  always @(negedge clk) begin
    if (rst == 1'b0) begin
      if (mem_req_valid && mem_req_ready) begin
        chk("req_addr", {16'h0000, mem_req_addr}, {16'h0000, req_model});
        req_model = req_model + 16'h0001;
        pend.push_back(mem_req_addr);
        req_cnt++;
      end
      if (out_valid && out_ready) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pop: got pc %0h data %0h expected no output", out_pc, out_data);
        end else begin
          exp_tmp = exp_q.pop_front();
          chk("out_pc", {16'h0000, out_pc}, {16'h0000, exp_tmp[23:8]});
          chk("out_data", {24'h000000, out_data}, {24'h000000, exp_tmp[7:0]});
        end
      end
    end
  end

  // Memory model: answer in order, one cycle after acceptance, when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (resp_en && pend.size() != 0) begin
        resp_tmp       = pend.pop_front();
        mem_resp_valid = 1'b1;
        mem_resp_data  = resp_tmp[7:0];
      end else begin
        mem_resp_valid = 1'b0;
        mem_resp_data  = 8'h00;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int fl_cnt;
    bit got;
    logic [15:0] first_addr;

    // Reset and streaming from RESET_PC.
    tick();
    tick();
    rst = 1'b0;
    exp_range(RST_PC, 8);
    #4;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_flushing", {31'd0, flushing}, 32'd0);
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("rst_req_addr", {16'h0000, mem_req_addr}, {16'h0000, RST_PC});
    repeat (8) tick();
    mem_req_ready = 1'b0;
    wait_drain("p1_drain", 20);
    chk("p1_pops", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8) chk("p1_rate", pop_cyc[7] - pop_cyc[0], 7);

    // Back-pressure: buffer plus outstanding capped at DEPTH.
    exp_range(16'hC008, 6);
    out_ready = 1'b0;
    mem_req_ready = 1'b1;
    base = req_cnt;
    repeat (10) tick();
    probe();
    chk("bp_req_count", req_cnt - base, 4);
    chk("bp_req_valid", {31'd0, mem_req_valid}, 32'd0);
    for (int k = 5; k <= 6; k++) begin
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
      probe();
      chk("bp_resume_count", req_cnt - base, k);
    end
    tick();
    out_ready = 1'b1;
    mem_req_ready = 1'b0;
    wait_drain("p2_drain", 20);

    // Redirect with nothing outstanding; addresses wrap at 16'hFFFF.
    redirect_valid = 1'b1;
    redirect_addr = 16'hFFFE;
    req_model = 16'hFFFE;
    exp_range(16'hFFFE, 4);
    tick();
    redirect_valid = 1'b0;
    mem_req_ready = 1'b1;
    probe();
    chk("rd_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("rd_req_addr", {16'h0000, mem_req_addr}, 32'h0000FFFE);
    repeat (4) tick();
    mem_req_ready = 1'b0;
    wait_drain("p3_drain", 20);

    // Redirect with 3 outstanding and 1 buffered byte.
    redirect_valid = 1'b1;
    redirect_addr = 16'h2000;
    req_model = 16'h2000;
    out_ready = 1'b0;
    resp_en = 1'b1;
    tick();
    redirect_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    tick();
    resp_en = 1'b0;
    tick();
    tick();
    mem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr = 16'h1234;
    req_model = 16'h1234;
    out_ready = 1'b1;
    exp_range(16'h1234, 2);
    tick();
    redirect_valid = 1'b0;
    resp_en = 1'b1;
    mem_req_ready = 1'b1;
    fl_cnt = 0;
    got = 1'b0;
    first_addr = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      probe();
      if (flushing) fl_cnt++;
      if (!got && mem_req_valid) begin
        got = 1'b1;
        first_addr = mem_req_addr;
      end
      tick();
    end
    mem_req_ready = 1'b0;
    chk("drain_cycles", fl_cnt, 3);
    chk("post_drain_req", {15'd0, got, first_addr}, {15'd0, 1'b1, 16'h1234});
    wait_drain("p4_drain", 20);

    // Redirect with a response and a pending pop, then redirect during DRAIN.
    out_ready = 1'b0;
    mem_req_ready = 1'b1;
    resp_en = 1'b1;
    tick();
    tick();
    resp_en = 1'b0;
    tick();
    mem_req_ready = 1'b0;
    resp_en = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr = 16'h3000;
    req_model = 16'h3000;
    probe();
    chk("redir_no_pop", {31'd0, out_valid}, 32'd0);
    chk("redir_no_req", {31'd0, mem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    resp_en = 1'b0;
    probe();
    chk("drain_after_resp", {31'd0, flushing}, 32'd1);
    tick();
    redirect_valid = 1'b1;
    redirect_addr = 16'h0500;
    req_model = 16'h0500;
    exp_range(16'h0500, 2);
    probe();
    chk("redir_in_drain", {31'd0, flushing}, 32'd1);
    tick();
    redirect_valid = 1'b0;
    resp_en = 1'b1;
    mem_req_ready = 1'b1;
    probe();
    chk("drain_last", {31'd0, flushing}, 32'd1);
    tick();
    probe();
    chk("drain_done", {31'd0, flushing}, 32'd0);
    chk("resume_req", {15'd0, mem_req_valid, mem_req_addr}, {15'd0, 1'b1, 16'h0500});
    tick();
    tick();
    mem_req_ready = 1'b0;
    wait_drain("p5_drain", 20);

    // Reset in the middle of DRAIN.
    mem_req_ready = 1'b1;
    resp_en = 1'b0;
    tick();
    tick();
    mem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr = 16'h4000;
    req_model = 16'h4000;
    tick();
    redirect_valid = 1'b0;
    probe();
    chk("pre_rst_flushing", {31'd0, flushing}, 32'd1);
    tick();
    rst = 1'b1;
    pend.delete();
    req_model = RST_PC;
    exp_range(RST_PC, 2);
    tick();
    rst = 1'b0;
    resp_en = 1'b1;
    mem_req_ready = 1'b1;
    probe();
    chk("mid_rst_flushing", {31'd0, flushing}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_req", {15'd0, mem_req_valid, mem_req_addr}, {15'd0, 1'b1, RST_PC});
    tick();
    tick();
    mem_req_ready = 1'b0;
    wait_drain("p6_drain", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
